// File: rtl/out_port_buffer_pkg.sv
// Shared sizing defaults for the OUT-port buffer and its storage array.
package out_port_buffer_pkg;

  localparam int OUT_PORT_WIDTH = 16;
  localparam int OUT_PORT_DEPTH = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_port_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module out_port_mem
  import out_port_buffer_pkg::*;
#(
  parameter int WIDTH = OUT_PORT_WIDTH,
  parameter int DEPTH = OUT_PORT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (waddr == PTR_W'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Storage needs no reset: the buffer's count decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_buffer.sv
// OUT-port FIFO between the Controller and an external device, with a sticky
// dropped-write flag. Pointer/count control lives here; storage is out_port_mem.
module out_port_buffer
  import out_port_buffer_pkg::*;
#(
  parameter int WIDTH = OUT_PORT_WIDTH,
  parameter int DEPTH = OUT_PORT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         outPortData,
  input  logic                     outSignalEn,
  input  logic                     portReady,
  input  logic                     clrOverflow,
  output logic [WIDTH-1:0]         portData,
  output logic                     portValid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             valid;
  logic             is_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] head_data;

  always_comb begin
    valid   = (count_q != '0);
    is_full = (count_q == DEPTH_C);
    pop     = valid & portReady;
    // A full buffer still takes a word when the head leaves in the same cycle.
    push    = outSignalEn & (~is_full | pop);
    drop    = outSignalEn & is_full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clrOverflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  out_port_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr_q),
    .wdata (outPortData),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  assign portValid = valid;
  assign portData  = valid ? head_data : '0;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed bench for out_port_buffer: order, overflow, full push/pop, latency, wrap, reset.
module tb_out_port_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] outPortData;
  logic             outSignalEn;
  logic             portReady;
  logic             clrOverflow;
  logic [WIDTH-1:0] portData;
  logic             portValid;
  logic             full;
  logic [2:0]       count;
  logic             overflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  out_port_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .outPortData (outPortData),
    .outSignalEn (outSignalEn),
    .portReady   (portReady),
    .clrOverflow (clrOverflow),
    .portData    (portData),
    .portValid   (portValid),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
  );

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    outSignalEn = 1'b1;
    outPortData = w;
    step();
    outSignalEn = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] order_vec [4];
    logic [WIDTH-1:0] after_vec [4];
    order_vec[0] = 16'h0005; order_vec[1] = 16'h0019;
    order_vec[2] = 16'hFFFF; order_vec[3] = 16'hF320;
    after_vec[0] = 16'h0019; after_vec[1] = 16'hFFFF;
    after_vec[2] = 16'hF320; after_vec[3] = 16'hAAAA;

    reset = 1'b1; outPortData = '0; outSignalEn = 1'b0;
    portReady = 1'b0; clrOverflow = 1'b0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_valid", portValid, 0);
    chk("rst_data", portData, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);

    // Fill directly after reset release: first word is pushed in the first free cycle.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_word(order_vec[i]);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);

    portReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_valid", portValid, 1);
      chk("order_data", portData, order_vec[i]);
      step();
    end
    chk("drain_valid", portValid, 0);
    chk("drain_data", portData, 0);
    chk("drain_count", count, 0);
    portReady = 1'b0;

    // Overflow: refill, then a dropped write.
    for (int i = 0; i < 4; i++) push_word(order_vec[i]);
    push_word(16'h1234);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", portData, 16'h0005);
    for (int i = 0; i < 10; i++) step();
    chk("ovf_sticky", overflow, 1);
    outSignalEn = 1'b1; outPortData = 16'h5678; clrOverflow = 1'b1;
    step();
    outSignalEn = 1'b0; clrOverflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    chk("ovf_cnt_keep", count, 4);

    // Push and pop while full.
    portReady = 1'b1;
    push_word(16'hAAAA);
    portReady = 1'b0;
    chk("fpp_count", count, 4);
    chk("fpp_head", portData, 16'h0019);
    chk("fpp_full", full, 1);
    portReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fpp_order", portData, after_vec[i]);
      step();
    end
    chk("fpp_empty", portValid, 0);

    // Latency into empty buffer with consumer ready.
    outSignalEn = 1'b1; outPortData = 16'h0042;
    chk("lat_push_cyc", portValid, 0);
    step();
    outSignalEn = 1'b0;
    chk("lat_valid", portValid, 1);
    chk("lat_data", portData, 16'h0042);
    step();
    chk("lat_empty", portValid, 0);
    chk("lat_data0", portData, 0);

    // Wrap-around with streaming push/pop pairs.
    for (int i = 1; i <= 10; i++) begin
      push_word(WIDTH'(i));
      chk("wrap_data", portData, i);
      chk("wrap_count", count, 1);
    end
    step();
    chk("wrap_end_cnt", count, 0);
    portReady = 1'b0;

    // Reset mid-operation with count = 3 and overflow set.
    push_word(16'h0011); push_word(16'h0022);
    push_word(16'h0033); push_word(16'h0044);
    push_word(16'h0055);
    portReady = 1'b1;
    step();
    portReady = 1'b0;
    chk("mid_count", count, 3);
    chk("mid_ovf", overflow, 1);
    reset = 1'b1; outSignalEn = 1'b1; outPortData = 16'hDEAD;
    step();
    reset = 1'b0; outSignalEn = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_valid", portValid, 0);
    chk("mrst_ovf", overflow, 0);
    push_word(16'h0BEE);
    chk("mrst_first", portData, 16'h0BEE);
    chk("mrst_cnt1", count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
